// File: rtl/uart_alu_interface.sv
// Frame sequencer between rx_uart/tx_uart and the combinational ALU.
// Collects operand A, operand B and opcode bytes, runs one ALU cycle,
// then issues a single transmit request carrying the latched result.
module uart_alu_interface #(
  parameter int unsigned NB_DATA        = 8,
  parameter int unsigned NB_OP          = 6,
  parameter int unsigned NB_STATE       = 3,
  parameter int unsigned NB_TIMEOUT     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 50_000_000
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_rx_done_tick,
  input  logic [NB_DATA-1:0] i_rx_data,
  input  logic [NB_DATA-1:0] i_alu_result,
  input  logic               i_tx_done_tick,
  output logic [NB_DATA-1:0] o_alu_a,
  output logic [NB_DATA-1:0] o_alu_b,
  output logic [NB_OP-1:0]   o_alu_op,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_tx_start,
  output logic               o_busy,
  output logic               o_error
);

  typedef enum logic [NB_STATE-1:0] {
    StIdle,
    StWaitB,
    StWaitOp,
    StExec,
    StSend,
    StWaitTx
  } state_e;

  localparam logic [NB_OP-1:0] OpAdd = NB_OP'(6'h20);
  localparam logic [NB_OP-1:0] OpSub = NB_OP'(6'h22);
  localparam logic [NB_OP-1:0] OpAnd = NB_OP'(6'h24);
  localparam logic [NB_OP-1:0] OpOr  = NB_OP'(6'h25);
  localparam logic [NB_OP-1:0] OpXor = NB_OP'(6'h26);
  localparam logic [NB_OP-1:0] OpNor = NB_OP'(6'h27);
  localparam logic [NB_OP-1:0] OpSra = NB_OP'(6'h03);
  localparam logic [NB_OP-1:0] OpSrl = NB_OP'(6'h02);

  localparam bit                    TimeoutEn   = (TIMEOUT_CYCLES != 0);
  // Counter value on the last waiting cycle before expiry.
  localparam logic [NB_TIMEOUT-1:0] TimeoutLast = NB_TIMEOUT'(TIMEOUT_CYCLES - 1);

  function automatic logic op_valid(input logic [NB_OP-1:0] op);
    case (op)
      OpAdd, OpSub, OpAnd, OpOr, OpXor, OpNor, OpSra, OpSrl: op_valid = 1'b1;
      default:                                               op_valid = 1'b0;
    endcase
  endfunction

  state_e                  state_q, state_d;
  logic [NB_DATA-1:0]      a_q, a_d, b_q, b_d, tx_q, tx_d;
  logic [NB_OP-1:0]        op_q, op_d;
  logic [NB_TIMEOUT-1:0]   cnt_q, cnt_d;
  logic                    err_q, err_d;
  logic                    timeout_hit;

  assign timeout_hit = TimeoutEn && (cnt_q == TimeoutLast);

  // Next-state, operand capture and inter-byte timeout.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    tx_d    = tx_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (i_rx_done_tick) begin
          a_d     = i_rx_data;
          state_d = StWaitB;
        end
      end
      StWaitB, StWaitOp: begin
        // An arriving byte takes priority over a simultaneous expiry.
        if (i_rx_done_tick) begin
          cnt_d = '0;
          if (state_q == StWaitB) begin
            b_d     = i_rx_data;
            state_d = StWaitOp;
          end else if (op_valid(i_rx_data[NB_OP-1:0])) begin
            op_d    = i_rx_data[NB_OP-1:0];
            state_d = StExec;
          end else begin
            err_d   = 1'b1;
            state_d = StIdle;
          end
        end else if (timeout_hit) begin
          cnt_d   = '0;
          err_d   = 1'b1;
          state_d = StIdle;
        end else if (TimeoutEn) begin
          cnt_d = cnt_q + NB_TIMEOUT'(1);
        end
      end
      StExec: begin
        tx_d    = i_alu_result;
        state_d = StSend;
      end
      StSend: state_d = StWaitTx;
      StWaitTx: begin
        if (i_tx_done_tick) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      tx_q    <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      tx_q    <= tx_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Reset masks the start request combinationally so a reset during SEND never leaks a pulse.
  always_comb begin
    o_tx_start = (state_q == StSend) && !i_reset;
    o_busy     = (state_q != StIdle);
  end

  assign o_alu_a   = a_q;
  assign o_alu_b   = b_q;
  assign o_alu_op  = op_q;
  assign o_tx_data = tx_q;
  assign o_error   = err_q;

endmodule
